// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   - WORD_SIZE_DEF : default data/address/instruction width
//   - fetch_state_e : fetch FSM state encoding
package fetch_pkg;

  localparam int WORD_SIZE_DEF = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    ERROR = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO, DEPTH entries of W bits, with synchronous flush.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   flush           : empty the queue this cycle (wins over push)
//   push, push_data : write an entry at the tail
//   pop             : retire the head entry (ignored when empty)
//   head_valid      : queue non-empty
//   head_data       : head entry, zero when empty
//   count           : current occupancy (0..DEPTH)
module fetch_queue #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic                     head_valid,
  output logic [W-1:0]             head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [AW:0]             cnt;
  logic                    do_pop;

  assign do_pop = pop && (cnt != '0);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset; the valid count gates what is visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Head comes straight from the storage flops, so a written entry is
  // visible the cycle after the write with no extra pipeline stage.
  assign head_valid = (cnt != '0);
  assign head_data  = head_valid ? mem[rd_ptr] : '0;
  assign count      = cnt;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues single outstanding memory reads, buffers
// returned instructions in a prefetch queue and hands them to a consumer
// with a valid/ready handshake. Redirects flush the queue and restart
// fetching; an in-flight read is drained and its data discarded.
// Optional build macro: FETCH_TIMEOUT_EN adds a memory wait timeout that
// parks the FSM in ERROR with fetch_error=1 until reset.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   readM, address        : memory read request and address
//   data, inputReady      : memory read data and its valid strobe
//   redirect, redirect_pc : control-flow change and new fetch address
//   inst_valid/inst/inst_pc, inst_ready : queue head handshake
//   num_inst              : count of delivered instructions (wraps)
//   fetch_error           : sticky memory timeout flag
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                   WORD_SIZE      = WORD_SIZE_DEF,
  parameter int                   DEPTH          = 4,
  parameter logic [WORD_SIZE-1:0] RESET_PC       = '0,
  parameter int                   TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 readM,
  output logic [WORD_SIZE-1:0] address,
  input  logic [WORD_SIZE-1:0] data,
  input  logic                 inputReady,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 inst_valid,
  output logic [WORD_SIZE-1:0] inst,
  output logic [WORD_SIZE-1:0] inst_pc,
  input  logic                 inst_ready,
  output logic [WORD_SIZE-1:0] num_inst,
  output logic                 fetch_error
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e             state, state_nxt;
  logic [WORD_SIZE-1:0]     fetch_pc, addr_q, num_q;
  logic                     push, pop;
  logic [2*WORD_SIZE-1:0]   q_head;
  logic [CNT_W-1:0]         q_count;

`ifdef FETCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;
  logic          timeout_hit;

  always_ff @(posedge clk) begin
    if (reset)
      wait_cnt <= '0;
    else if ((state == WAIT || state == DRAIN) && !inputReady)
      wait_cnt <= wait_cnt + TW'(1);
    else
      wait_cnt <= '0;
  end

  // Fires on the last allowed wait cycle; ERROR follows on the next edge.
  assign timeout_hit = !inputReady && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign fetch_error = (state == ERROR);
`else
  assign fetch_error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    case (state)
      IDLE:  if (q_count != CNT_W'(DEPTH)) state_nxt = REQ;
      REQ:   state_nxt = redirect ? DRAIN : WAIT;
      WAIT: begin
        if (inputReady) begin
          state_nxt = IDLE;
          push      = !redirect;   // data racing a redirect is stale
        end else if (redirect) begin
          state_nxt = DRAIN;
`ifdef FETCH_TIMEOUT_EN
        end else if (timeout_hit) begin
          state_nxt = ERROR;
`endif
        end
      end
      DRAIN: begin
        if (inputReady) state_nxt = IDLE;
`ifdef FETCH_TIMEOUT_EN
        else if (timeout_hit) state_nxt = ERROR;
`endif
      end
`ifdef FETCH_TIMEOUT_EN
      ERROR: state_nxt = ERROR;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Redirect beats a same-cycle pop: the head being accepted is flushed.
  assign pop = inst_valid && inst_ready && !redirect;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      addr_q   <= RESET_PC;
      num_q    <= '0;
    end else begin
      if (redirect)  fetch_pc <= redirect_pc;
      else if (push) fetch_pc <= addr_q + WORD_SIZE'(1);
      // Latch the request address on IDLE->REQ so it stays stable
      // through WAIT/DRAIN even if fetch_pc is redirected meanwhile.
      if (state == IDLE && state_nxt == REQ)
        addr_q <= redirect ? redirect_pc : fetch_pc;
      if (pop) num_q <= num_q + WORD_SIZE'(1);
    end
  end

  fetch_queue #(
    .W     (2*WORD_SIZE),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect),
    .push       (push),
    .push_data  ({data, addr_q}),
    .pop        (pop),
    .head_valid (inst_valid),
    .head_data  (q_head),
    .count      (q_count)
  );

  assign readM    = (state == REQ) || (state == WAIT) || (state == DRAIN);
  assign address  = addr_q;
  assign inst     = q_head[2*WORD_SIZE-1:WORD_SIZE];
  assign inst_pc  = q_head[WORD_SIZE-1:0];
  assign num_inst = num_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit (default parameters).
// A memory model answers reads after `lat` cycles with address+0x1111 and
// logs every new request address; a manual path drives exact timings.
module tb_fetch_unit;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         readM;
  logic [W-1:0] address, data;
  logic         inputReady;
  logic         redirect;
  logic [W-1:0] redirect_pc;
  logic         inst_valid;
  logic [W-1:0] inst, inst_pc, num_inst;
  logic         inst_ready;
  logic         fetch_error;

  bit           mem_en;
  int           lat;
  logic         mdl_ready, man_ready;
  logic [W-1:0] mdl_data, man_data;
  logic [W-1:0] log_q[$];
  int           base;
  int           n_cmp = 0;
  int           n_err = 0;

  typedef struct {
    logic         rdy;
    logic         redir;
    logic [W-1:0] rpc;
    logic         e_valid;
    logic [W-1:0] e_inst;
    logic [W-1:0] e_pc;
    logic [W-1:0] e_num;
  } vec_t;

  vec_t tbl[6];

  assign inputReady = mem_en ? mdl_ready : man_ready;
  assign data       = mem_en ? mdl_data  : man_data;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .readM       (readM),
    .address     (address),
    .data        (data),
    .inputReady  (inputReady),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .num_inst    (num_inst),
    .fetch_error (fetch_error)
  );

  // Memory model and request logger, acting just after each rising edge.
  initial begin : mem_model
    int   cnt;
    logic prev_rm;
    cnt = 0; prev_rm = 1'b0; mdl_ready = 1'b0; mdl_data = '0;
    forever begin
      @(posedge clk); #1;
      if (readM && !prev_rm) log_q.push_back(address);
      prev_rm   = readM;
      mdl_ready = 1'b0;
      if (mem_en && readM) begin
        cnt++;
        if (cnt >= lat) begin
          mdl_ready = 1'b1;
          mdl_data  = address + 16'h1111;
          cnt       = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] get_log(input int i);
    if (i < log_q.size()) return {16'h0, log_q[i]};
    return 32'hDEADBEEF;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    mem_en = 1'b0; reset = 1'b1; redirect = 1'b0; inst_ready = 1'b0; man_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Wait (bounded) until n requests have been logged since base.
  task automatic wait_log(input int n, input string nm);
    int k;
    for (k = 0; k < 200; k++) begin
      if (log_q.size() - base >= n) break;
      @(negedge clk);
    end
    chk(nm, 32'(k < 200), 32'd1);
  endtask

  initial begin
    int k;
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    mem_en = 1'b0; lat = 3; man_ready = 1'b0; man_data = '0;

    // queue drain sequence, starting from a full queue holding addresses 0..3
    tbl[0] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h1111, 16'h0000, 16'd0};
    tbl[1] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h1112, 16'h0001, 16'd1};
    tbl[2] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h1113, 16'h0002, 16'd2};
    tbl[3] = '{1'b1, 1'b1, 16'h0040, 1'b1, 16'h1113, 16'h0002, 16'd2};
    tbl[4] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'd2};
    tbl[5] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'd2};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_readM",      32'(readM),       32'd0);
    chk("rst_address",    32'(address),     32'd0);
    chk("rst_inst_valid", 32'(inst_valid),  32'd0);
    chk("rst_inst",       32'(inst),        32'd0);
    chk("rst_inst_pc",    32'(inst_pc),     32'd0);
    chk("rst_num_inst",   32'(num_inst),    32'd0);
    chk("rst_fetch_err",  32'(fetch_error), 32'd0);

    // Basic fetch: 3-cycle memory, consumer always ready
    base = log_q.size(); mem_en = 1'b1; lat = 3; inst_ready = 1'b1; reset = 1'b0;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (inst_valid) break;
    end
    chk("basic_wait",  32'(k < 50),    32'd1);
    chk("basic_inst",  32'(inst),      32'h1111);
    chk("basic_pc",    32'(inst_pc),   32'h0);
    chk("basic_addr",  get_log(base),  32'h0);
    @(negedge clk);
    chk("basic_num",   32'(num_inst),  32'd1);

    // Fill: no consumer, exactly DEPTH requests then readM idles
    do_reset();
    base = log_q.size(); mem_en = 1'b1; lat = 3; inst_ready = 1'b0;
    wait_log(4, "fill_wait");
    repeat (10) @(negedge clk);
    chk("fill_reqs",  32'(log_q.size() - base), 32'd4);
    chk("fill_readM", 32'(readM), 32'd0);
    for (int i = 0; i < 4; i++) chk($sformatf("fill_addr%0d", i), get_log(base + i), 32'(i));
    mem_en = 1'b0;

    // Table: pops, redirect racing a pop, flushed head
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("tbl%0d_valid", i), 32'(inst_valid), 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_inst", i),  32'(inst),       32'(tbl[i].e_inst));
      chk($sformatf("tbl%0d_pc", i),    32'(inst_pc),    32'(tbl[i].e_pc));
      chk($sformatf("tbl%0d_num", i),   32'(num_inst),   32'(tbl[i].e_num));
      inst_ready = tbl[i].rdy; redirect = tbl[i].redir; redirect_pc = tbl[i].rpc;
      @(negedge clk);
    end
    inst_ready = 1'b0; redirect = 1'b0;
    chk("refill_addr",   get_log(base + 4), 32'h4);
    chk("drain_readM",   32'(readM),   32'd1);
    chk("drain_address", 32'(address), 32'h4);

    // Redirect while waiting on address 2
    do_reset();
    base = log_q.size(); mem_en = 1'b1; lat = 3; inst_ready = 1'b1;
    wait_log(3, "rd_wait");
    chk("rd_pre_addr", get_log(base + 2), 32'h2);
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 16'h0040;
    @(negedge clk);
    redirect = 1'b0;
    chk("rd_drain_readM", 32'(readM),   32'd1);
    chk("rd_drain_addr",  32'(address), 32'h2);
    @(negedge clk);
    chk("rd_valid", 32'(inst_valid), 32'd0);
    chk("rd_num",   32'(num_inst),   32'd2);
    chk("rd_readM", 32'(readM),      32'd0);
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (inst_valid) break;
    end
    chk("rd_new_wait", 32'(k < 50), 32'd1);
    chk("rd_new_addr", get_log(base + 3), 32'h40);
    chk("rd_new_pc",   32'(inst_pc), 32'h40);
    chk("rd_new_inst", 32'(inst),    32'h1151);

    // Reset during WAIT, stale inputReady arrives 2 cycles later
    do_reset();
    base = log_q.size(); inst_ready = 1'b0;
    wait_log(1, "rs_wait0");
    @(negedge clk);
    man_ready = 1'b1; man_data = 16'hAAAA;
    @(negedge clk);
    man_ready = 1'b0;
    wait_log(2, "rs_wait1");
    @(negedge clk);
    chk("rs_wait_addr", 32'(address), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; man_ready = 1'b1; man_data = 16'hDEAD;
    @(negedge clk);
    man_ready = 1'b0;
    chk("rs_valid",  32'(inst_valid), 32'd0);
    chk("rs_first",  get_log(base + 2), 32'h0);
    @(negedge clk);
    chk("rs_valid2", 32'(inst_valid), 32'd0);
    chk("rs_readM",  32'(readM),      32'd1);
    man_ready = 1'b1; man_data = 16'h2222;
    @(negedge clk);
    man_ready = 1'b0;
    chk("rs_valid3", 32'(inst_valid), 32'd1);
    chk("rs_inst",   32'(inst),       32'h2222);
    chk("rs_pc",     32'(inst_pc),    32'h0);
    chk("rs_num",    32'(num_inst),   32'd0);

    // Memory never answers
    do_reset();
    base = log_q.size();
    repeat (30) @(negedge clk);
    chk("to_early_err",   32'(fetch_error), 32'd0);
    chk("to_early_readM", 32'(readM),       32'd1);
    repeat (50) @(negedge clk);
`ifdef FETCH_TIMEOUT_EN
    chk("to_err",   32'(fetch_error), 32'd1);
    chk("to_readM", 32'(readM),       32'd0);
    repeat (20) @(negedge clk);
    chk("to_err_hold",   32'(fetch_error), 32'd1);
    chk("to_readM_hold", 32'(readM),       32'd0);
    chk("to_no_refetch", 32'(log_q.size() - base), 32'd1);
`else
    chk("to_err",   32'(fetch_error), 32'd0);
    chk("to_readM", 32'(readM),       32'd1);
    chk("to_addr",  32'(address),     32'h0);
`endif
    do_reset();
    chk("to_err_cleared", 32'(fetch_error), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
